// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the 20-bit pipelined processor.
// Holds the data memory, performs stores and synchronous loads, and registers
// the MEM/WB fields consumed by writeBack. Supports stall (hold) and flush
// (bubble insertion).
//
// Optional feature: define MEM_ACCESS_COUNT_EN to add saturating load/store
// access counters (load_count, store_count).
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high
//   stall           hold all MEM/WB registers, suppress the store
//   flush           load BUBBLE into MEM/WB, suppress the store
//   valid_in        EX/MEM entry is a real instruction
//   instruction_in  instruction, opcode = [19:16]
//   aluRESULT_in    ALU result, memory address = [ADDR_W-1:0]
//   dataRFOut1_in   RF operand 1
//   dataRFOut2_in   RF operand 2, store data
//   address_in      destination register
//   valid_out       MEM/WB entry valid
//   instruction     registered instruction
//   aluRESULTout    registered ALU result
//   dataRFOut1      registered operand 1
//   dataRFOut2      registered operand 2
//   memoryReadData  load data (aligned with the other registered fields)
//   address         registered destination register
//   load_count      accepted valid loads   (MEM_ACCESS_COUNT_EN only)
//   store_count     performed stores       (MEM_ACCESS_COUNT_EN only)
module memory_stage #(
  parameter int          ADDR_W = 8,
  parameter logic [19:0] BUBBLE = 20'hC0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [19:0] instruction_in,
  input  logic [19:0] aluRESULT_in,
  input  logic [19:0] dataRFOut1_in,
  input  logic [19:0] dataRFOut2_in,
  input  logic [3:0]  address_in,
  output logic        valid_out,
  output logic [19:0] instruction,
  output logic [19:0] aluRESULTout,
  output logic [19:0] dataRFOut1,
  output logic [19:0] dataRFOut2,
  output logic [19:0] memoryReadData,
  output logic [3:0]  address
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0] load_count,
  output logic [15:0] store_count
`endif
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] OP_STORE = 4'hC;
  localparam logic [3:0] OP_LOADA = 4'hF;
  localparam logic [3:0] OP_LOADB = 4'hD;

  logic [19:0]       mem [DEPTH];
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] memAddr;
  logic              advance;
  logic              doStore;
  logic              doLoad;

  assign opcode  = instruction_in[19:16];
  // Upper ALU result bits are dropped, so addresses wrap modulo DEPTH.
  assign memAddr = aluRESULT_in[ADDR_W-1:0];
  assign advance = !reset && !flush && !stall;
  assign doStore = advance && valid_in && (opcode == OP_STORE);
  assign doLoad  = advance && valid_in && ((opcode == OP_LOADA) || (opcode == OP_LOADB));

  // Memory contents survive reset; only the pipeline registers are cleared.
  always_ff @(posedge clock) begin
    if (doStore) mem[memAddr] <= dataRFOut2_in;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      valid_out      <= 1'b0;
      instruction    <= BUBBLE;
      aluRESULTout   <= '0;
      dataRFOut1     <= '0;
      dataRFOut2     <= '0;
      memoryReadData <= '0;
      address        <= '0;
    end else if (!stall) begin
      valid_out      <= valid_in;
      instruction    <= valid_in ? instruction_in : BUBBLE;
      aluRESULTout   <= aluRESULT_in;
      dataRFOut1     <= dataRFOut1_in;
      dataRFOut2     <= dataRFOut2_in;
      address        <= address_in;
      // A store in the previous cycle has already landed, so a following
      // load to the same address sees the new value.
      memoryReadData <= doLoad ? mem[memAddr] : '0;
    end
  end

`ifdef MEM_ACCESS_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      load_count  <= '0;
      store_count <= '0;
    end else begin
      if (doLoad && (load_count != 16'hFFFF))   load_count  <= load_count + 16'd1;
      if (doStore && (store_count != 16'hFFFF)) store_count <= store_count + 16'd1;
    end
  end
`endif

endmodule
